// File: rtl/rc_cpl_adapt_pkg.sv
// RC completion adapter: descriptor offsets, fmt/type codes and TLP header layout.
// Shared by rc_cpl_adapt and its testbench-visible structure.
package rc_cpl_adapt_pkg;

  localparam int LOWADDR_LSB = 0;
  localparam int BYTECNT_LSB = 16;
  localparam int LOCKED_BIT  = 29;
  localparam int DWLEN_LSB   = 32;
  localparam int STATUS_LSB  = 43;
  localparam int POISON_BIT  = 46;
  localparam int REQID_LSB   = 48;
  localparam int TAG_LSB     = 64;
  localparam int CPLID_LSB   = 72;
  localparam int TC_LSB      = 89;
  localparam int ATTR_LSB    = 92;

  localparam logic [4:0] TYPE_CPL   = 5'h0A;
  localparam logic [4:0] TYPE_CPLLK = 5'h0B;
  localparam logic [2:0] FMT_NODATA = 3'b000;
  localparam logic [2:0] FMT_DATA   = 3'b010;

  typedef struct packed {
    logic [31:0] dw3;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic        rsv2;
    logic [6:0]  lowaddr;
    logic [15:0] completer_id;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] bytecnt;
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic        rsv1;
    logic [2:0]  tc;
    logic [3:0]  rsv0;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  at;
    logic [9:0]  dwlen;
  } cpl_hdr_t;

  function automatic logic [7:0] fmt_type(
    input logic        locked,
    input logic [11:0] bytecnt
  );
    logic [2:0] f;
    logic [4:0] t;
    f = (bytecnt != '0) ? FMT_DATA : FMT_NODATA;
    t = locked ? TYPE_CPLLK : TYPE_CPL;
    return {f, t};
  endfunction

endpackage

// File: rtl/rc_cpl_skid.sv
// Width-generic 2-entry register slice: output register plus one skid entry.
// Upstream ready is registered and means "skid entry empty".
module rc_cpl_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic         rdy_q, rdy_d;
  logic         out_vld_q, out_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         s_fire;

  assign s_fire = s_valid & rdy_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (!out_vld_q || m_ready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = s_fire;
        if (s_fire) out_d = s_data;
      end
    end else if (s_fire) begin
      skid_d     = s_data;
      skid_vld_d = 1'b1;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

  assign s_ready = rdy_q;
  assign m_data  = out_q;
  assign m_valid = out_vld_q;

endmodule

// File: rtl/rc_cpl_adapt.sv
// RC completion descriptor -> PCIe 3-DW completion header adapter.
// Define RC_CPL_ADAPT_STATS_EN to build the completion/poison/discontinue counters.
module rc_cpl_adapt
  import rc_cpl_adapt_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int DW_WIDTH   = DATA_WIDTH/32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_rc_tdata,
  input  logic [DW_WIDTH-1:0]   s_axis_rc_tkeep,
  input  logic                  s_axis_rc_tlast,
  input  logic                  s_axis_rc_discontinue,
  input  logic                  s_axis_rc_tvalid,
  output logic [3:0]            s_axis_rc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_rc_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep,
  output logic                  m_axis_rc_tlast,
  output logic                  m_axis_rc_poison,
  output logic                  m_axis_rc_discontinue,
  output logic                  m_axis_rc_tvalid,
  input  logic                  m_axis_rc_tready,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  stats_cpl,
  output logic [CNT_WIDTH-1:0]  stats_poison,
  output logic [CNT_WIDTH-1:0]  stats_disc
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 3;

  logic                  in_pkt_q, in_pkt_d;
  logic                  pois_q, pois_d;
  logic                  rdy, in_fire, sop;
  cpl_hdr_t              hdr;
  logic [DATA_WIDTH-1:0] tdata_x;
  logic [KEEP_WIDTH-1:0] tkeep_x;
  logic                  pois_x;
  logic [PW-1:0]         skid_in, skid_out;

  assign in_fire = s_axis_rc_tvalid & rdy;
  assign sop     = ~in_pkt_q;

  always_comb begin
    hdr              = '0;
    hdr.dw3          = s_axis_rc_tdata[127:96];
    hdr.requester_id = s_axis_rc_tdata[REQID_LSB +: 16];
    hdr.tag          = s_axis_rc_tdata[TAG_LSB +: 8];
    hdr.lowaddr      = s_axis_rc_tdata[LOWADDR_LSB +: 7];
    hdr.completer_id = s_axis_rc_tdata[CPLID_LSB +: 16];
    hdr.status       = s_axis_rc_tdata[STATUS_LSB +: 3];
    hdr.bytecnt      = s_axis_rc_tdata[BYTECNT_LSB +: 12];
    {hdr.fmt, hdr.typ} = fmt_type(s_axis_rc_tdata[LOCKED_BIT],
                                  s_axis_rc_tdata[BYTECNT_LSB +: 12]);
    hdr.tc           = s_axis_rc_tdata[TC_LSB +: 3];
    hdr.attr         = s_axis_rc_tdata[ATTR_LSB +: 2];
    hdr.dwlen        = s_axis_rc_tdata[DWLEN_LSB +: 10];

    tdata_x = s_axis_rc_tdata;
    if (sop) tdata_x[127:0] = hdr;

    tkeep_x = '0;
    for (int i = 0; i < DW_WIDTH; i++) begin
      tkeep_x[4*i +: 4] = {4{s_axis_rc_tkeep[i]}};
    end
    // The 3-DW header is always fully valid regardless of PHY keep
    if (sop) tkeep_x[11:0] = '1;

    pois_x = sop ? s_axis_rc_tdata[POISON_BIT] : pois_q;
  end

  always_comb begin
    in_pkt_d = in_pkt_q;
    pois_d   = pois_q;
    if (in_fire) begin
      in_pkt_d = ~s_axis_rc_tlast;
      if (sop) pois_d = s_axis_rc_tdata[POISON_BIT];
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      in_pkt_q <= 1'b0;
      pois_q   <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      pois_q   <= pois_d;
    end
  end

  assign skid_in = {tdata_x, tkeep_x, s_axis_rc_tlast,
                    pois_x, s_axis_rc_discontinue};

  rc_cpl_skid #(
    .W (PW)
  ) u_skid (
    .clk     (user_clk),
    .rst     (user_reset),
    .s_data  (skid_in),
    .s_valid (s_axis_rc_tvalid),
    .s_ready (rdy),
    .m_data  (skid_out),
    .m_valid (m_axis_rc_tvalid),
    .m_ready (m_axis_rc_tready)
  );

  assign {m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast,
          m_axis_rc_poison, m_axis_rc_discontinue} = skid_out;

  assign s_axis_rc_tready = {4{rdy}};

`ifdef RC_CPL_ADAPT_STATS_EN
  logic [CNT_WIDTH-1:0] stats_cpl_q, stats_cpl_d;
  logic [CNT_WIDTH-1:0] stats_pois_q, stats_pois_d;
  logic [CNT_WIDTH-1:0] stats_disc_q, stats_disc_d;
  logic                 disc_seen_q, disc_seen_d;
  logic                 disc_any;

  assign disc_any = disc_seen_q | s_axis_rc_discontinue;

  always_comb begin
    stats_cpl_d  = stats_cpl_q;
    stats_pois_d = stats_pois_q;
    stats_disc_d = stats_disc_q;
    disc_seen_d  = disc_seen_q;
    if (in_fire) begin
      disc_seen_d = disc_any;
      if (s_axis_rc_tlast) begin
        disc_seen_d = 1'b0;
        if (~&stats_cpl_q) stats_cpl_d = stats_cpl_q + 1'b1;
        if (pois_x && ~&stats_pois_q) stats_pois_d = stats_pois_q + 1'b1;
        if (disc_any && ~&stats_disc_q) stats_disc_d = stats_disc_q + 1'b1;
      end
    end
    if (stats_clr) begin
      stats_cpl_d  = '0;
      stats_pois_d = '0;
      stats_disc_d = '0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      stats_cpl_q  <= '0;
      stats_pois_q <= '0;
      stats_disc_q <= '0;
      disc_seen_q  <= 1'b0;
    end else begin
      stats_cpl_q  <= stats_cpl_d;
      stats_pois_q <= stats_pois_d;
      stats_disc_q <= stats_disc_d;
      disc_seen_q  <= disc_seen_d;
    end
  end

  assign stats_cpl    = stats_cpl_q;
  assign stats_poison = stats_pois_q;
  assign stats_disc   = stats_disc_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stats_cpl    = '0;
  assign stats_poison = '0;
  assign stats_disc   = '0;
`endif

endmodule

// File: tb/tb_rc_cpl_adapt.sv
// Bench for rc_cpl_adapt: directed descriptor cases plus randomized
// backpressure against a queue-based conversion model.
module tb_rc_cpl_adapt;

  localparam int DO = 67;

  logic         user_clk = 1'b0;
  logic         user_reset;
  logic [511:0] s_axis_rc_tdata;
  logic [15:0]  s_axis_rc_tkeep;
  logic         s_axis_rc_tlast;
  logic         s_axis_rc_discontinue;
  logic         s_axis_rc_tvalid;
  logic [3:0]   s_axis_rc_tready;
  logic [511:0] m_axis_rc_tdata;
  logic [63:0]  m_axis_rc_tkeep;
  logic         m_axis_rc_tlast;
  logic         m_axis_rc_poison;
  logic         m_axis_rc_discontinue;
  logic         m_axis_rc_tvalid;
  logic         m_axis_rc_tready;
  logic         stats_clr;
  logic [15:0]  stats_cpl;
  logic [15:0]  stats_poison;
  logic [15:0]  stats_disc;

  rc_cpl_adapt dut (
    .user_clk              (user_clk),
    .user_reset            (user_reset),
    .s_axis_rc_tdata       (s_axis_rc_tdata),
    .s_axis_rc_tkeep       (s_axis_rc_tkeep),
    .s_axis_rc_tlast       (s_axis_rc_tlast),
    .s_axis_rc_discontinue (s_axis_rc_discontinue),
    .s_axis_rc_tvalid      (s_axis_rc_tvalid),
    .s_axis_rc_tready      (s_axis_rc_tready),
    .m_axis_rc_tdata       (m_axis_rc_tdata),
    .m_axis_rc_tkeep       (m_axis_rc_tkeep),
    .m_axis_rc_tlast       (m_axis_rc_tlast),
    .m_axis_rc_poison      (m_axis_rc_poison),
    .m_axis_rc_discontinue (m_axis_rc_discontinue),
    .m_axis_rc_tvalid      (m_axis_rc_tvalid),
    .m_axis_rc_tready      (m_axis_rc_tready),
    .stats_clr             (stats_clr),
    .stats_cpl             (stats_cpl),
    .stats_poison          (stats_poison),
    .stats_disc            (stats_disc)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [639:0] v;
    int           cyc;
  } ent_t;

  ent_t         exp_q[$];
  logic         pois_log[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           n_out = 0;
  int           last_lat = 0;
  logic [639:0] last_out = '0;
  logic [639:0] hold_val = '0;
  logic         hold_v = 1'b0;
  logic         acc = 1'b0;
  logic         in_pkt = 1'b0;
  logic         plat = 1'b0;
  logic         disc_any = 1'b0;
  int           n_cpl = 0;
  int           n_pois = 0;
  int           n_disc = 0;

  task automatic chk(input string tag, input logic [639:0] got,
                     input logic [639:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected output beat, built field by field from the descriptor layout
  function automatic logic [639:0] model(
    input logic [511:0] d, input logic [15:0] k,
    input logic last, input logic disc,
    input logic first, input logic pl
  );
    logic [511:0] o;
    logic [63:0]  ko;
    logic         p;
    logic [11:0]  bc;
    logic [2:0]   fmt;
    logic [4:0]   typ;
    o  = d;
    p  = pl;
    for (int i = 0; i < 16; i++) ko[4*i +: 4] = {4{k[i]}};
    if (first) begin
      bc  = d[27:16];
      fmt = (bc == 12'd0) ? 3'b000 : 3'b010;
      typ = d[29] ? 5'h0B : 5'h0A;
      o[63:0] = {d[87:72], d[45:43], 1'b0, bc, fmt, typ, 1'b0,
                 d[91:89], 4'b0, 1'b0, 1'b0, d[93:92], 2'b0, d[41:32]};
      o[127:64] = {d[127:96], d[63:48], d[71:64], 1'b0, d[6:0]};
      ko[11:0] = 12'hFFF;
      p = d[46];
    end
    return {61'b0, o, ko, last, p, disc};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [511:0] desc(
    input logic [6:0] la, input logic [11:0] bc, input logic lk,
    input logic [9:0] dl, input logic [15:0] rq, input logic [7:0] tg,
    input logic [15:0] cp, input logic [2:0] tc, input logic [1:0] at,
    input logic ps
  );
    logic [511:0] d;
    d = rnd512();
    d[6:0] = la;   d[27:16] = bc;  d[29] = lk;
    d[41:32] = dl; d[45:43] = 3'd0; d[46] = ps;
    d[63:48] = rq; d[71:64] = tg;  d[87:72] = cp;
    d[91:89] = tc; d[93:92] = at;
    return d;
  endfunction

  task automatic step();
    logic [639:0] cur;
    logic [639:0] m;
    ent_t         e;
    logic         first;
    @(negedge user_clk);
    cur = {61'b0, m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast,
           m_axis_rc_poison, m_axis_rc_discontinue};
    acc = 1'b0;
    if (user_reset) begin
      exp_q.delete();
      hold_v = 1'b0;
      in_pkt = 1'b0;
      plat = 1'b0;
      disc_any = 1'b0;
      n_cpl = 0; n_pois = 0; n_disc = 0;
    end else begin
      if (hold_v) begin
        if (m_axis_rc_tvalid) chk("stable", cur, hold_val);
        else chk("vld_drop", m_axis_rc_tvalid, 1);
      end
      hold_v = m_axis_rc_tvalid && !m_axis_rc_tready;
      hold_val = cur;
      if (m_axis_rc_tvalid && m_axis_rc_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra", m_axis_rc_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e.v);
          last_out = cur;
          last_lat = cyc - e.cyc;
          pois_log.push_back(m_axis_rc_poison);
          n_out++;
        end
      end
      acc = s_axis_rc_tvalid && s_axis_rc_tready[0];
      if (acc) begin
        first = !in_pkt;
        m = model(s_axis_rc_tdata, s_axis_rc_tkeep, s_axis_rc_tlast,
                  s_axis_rc_discontinue, first, plat);
        exp_q.push_back('{m, cyc});
        if (first) plat = s_axis_rc_tdata[46];
        if (s_axis_rc_tlast) begin
          n_cpl++;
          if (m[1]) n_pois++;
          if (disc_any || s_axis_rc_discontinue) n_disc++;
          disc_any = 1'b0;
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
          disc_any = disc_any | s_axis_rc_discontinue;
        end
      end
      if (stats_clr) begin
        n_cpl = 0; n_pois = 0; n_disc = 0;
      end
    end
    @(posedge user_clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [511:0] d, input logic [15:0] k,
                      input logic last, input logic disc);
    s_axis_rc_tdata = d;
    s_axis_rc_tkeep = k;
    s_axis_rc_tlast = last;
    s_axis_rc_discontinue = disc;
    s_axis_rc_tvalid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    s_axis_rc_tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_beat();
    s_axis_rc_tdata = rnd512();
    s_axis_rc_tkeep = 16'($urandom);
    s_axis_rc_tlast = ($urandom_range(0, 3) == 0);
    s_axis_rc_discontinue = ($urandom_range(0, 15) == 0);
  endtask

  task automatic drain();
    s_axis_rc_tvalid = 1'b0;
    m_axis_rc_tready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    step();
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [511:0] d;
    int           n_acc;
    int           base;
    user_reset = 1'b1;
    s_axis_rc_tdata = '0;
    s_axis_rc_tkeep = '0;
    s_axis_rc_tlast = 1'b0;
    s_axis_rc_discontinue = 1'b0;
    s_axis_rc_tvalid = 1'b0;
    m_axis_rc_tready = 1'b1;
    stats_clr = 1'b0;

    idle(3);
    chk("rst_vld", m_axis_rc_tvalid, 0);
    chk("rst_rdy", s_axis_rc_tready, 0);
    chk("rst_stats", {stats_cpl, stats_poison, stats_disc}, 0);
    user_reset = 1'b0;
    idle(1);
    chk("rdy_after_rst", s_axis_rc_tready, 4'hF);

    send(desc(7'h10, 12'd16, 1'b0, 10'd4, 16'h0200, 8'h5A, 16'h0100,
              3'd2, 2'd1, 1'b0), 16'h0001, 1'b1, 1'b0);
    idle(1);
    chk("sop_dw0", last_out[DO +: 32], 32'h4A201004);
    chk("sop_dw1", last_out[DO+32 +: 32], 32'h01000010);
    chk("sop_dw2", last_out[DO+64 +: 32], 32'h02005A10);
    chk("sop_keep", last_out[3 +: 12], 12'hFFF);
    chk("sop_last", last_out[2], 1'b1);
    chk("latency", last_lat, 1);

    send(desc(7'h3, 12'd0, 1'b1, 10'd0, 16'h1, 8'h1, 16'h2, 3'd0, 2'd0,
              1'b0), 16'h0, 1'b1, 1'b0);
    idle(1);
    chk("cpllk_nodata", last_out[DO+24 +: 8], 8'h0B);
    send(desc(7'h3, 12'd0, 1'b0, 10'd0, 16'h1, 8'h1, 16'h2, 3'd0, 2'd0,
              1'b0), 16'h0, 1'b1, 1'b0);
    idle(1);
    chk("cpl_nodata", last_out[DO+24 +: 8], 8'h0A);

    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    pois_log.delete();
    send(desc(7'h0, 12'd32, 1'b0, 10'd8, 16'h3, 8'h7, 16'h4, 3'd1, 2'd0,
              1'b1), 16'hFFFF, 1'b0, 1'b0);
    d = rnd512(); d[46] = 1'b0;
    send(d, 16'hFFFF, 1'b0, 1'b0);
    d = rnd512(); d[46] = 1'b0;
    send(d, 16'h00FF, 1'b1, 1'b0);
    send(desc(7'h0, 12'd4, 1'b0, 10'd1, 16'h3, 8'h8, 16'h4, 3'd1, 2'd0,
              1'b0), 16'h000F, 1'b1, 1'b0);
    idle(2);
    chk("pois_cnt", pois_log.size(), 4);
    if (pois_log.size() == 4) begin
      chk("pois_b0", pois_log[0], 1'b1);
      chk("pois_b1", pois_log[1], 1'b1);
      chk("pois_b2", pois_log[2], 1'b1);
      chk("pois_clean", pois_log[3], 1'b0);
    end
`ifdef RC_CPL_ADAPT_STATS_EN
    chk("stats_cpl2", stats_cpl, 16'd2);
    chk("stats_pois1", stats_poison, 16'd1);
`else
    chk("stats_off", {stats_cpl, stats_poison, stats_disc}, 0);
`endif

    m_axis_rc_tready = 1'b0;
    send(desc(7'h1, 12'd64, 1'b0, 10'd16, 16'h5, 8'h9, 16'h6, 3'd0, 2'd0,
              1'b1), 16'hFFFF, 1'b0, 1'b0);
    s_axis_rc_tdata = rnd512();
    user_reset = 1'b1;
    step();
    chk("rst_mid_vld", m_axis_rc_tvalid, 0);
    user_reset = 1'b0;
    idle(1);
    chk("rst_mid_rdy", s_axis_rc_tready, 4'hF);
    m_axis_rc_tready = 1'b1;
    send(desc(7'h10, 12'd16, 1'b0, 10'd4, 16'h0200, 8'h5A, 16'h0100,
              3'd2, 2'd1, 1'b0), 16'hFFFF, 1'b0, 1'b0);
    send(rnd512(), 16'h0003, 1'b1, 1'b0);
    chk("rst_mid_sop", last_out[DO +: 32], 32'h4A201004);
    idle(2);

    drain();
    base = n_out;
    n_acc = 0;
    for (int i = 0; i < 64; i++) begin
      rand_beat();
      s_axis_rc_tvalid = 1'b1;
      step();
      if (acc) n_acc++;
    end
    idle(1);
    chk("thru_in", n_acc, 64);
    chk("thru_out", n_out - base, 64);

    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    n_acc = 0;
    acc = 1'b0;
    for (int t = 0; t < 20000 && n_acc < 1000; t++) begin
      if (!s_axis_rc_tvalid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          rand_beat();
          s_axis_rc_tvalid = 1'b1;
        end else begin
          s_axis_rc_tvalid = 1'b0;
        end
      end
      m_axis_rc_tready = 1'($urandom_range(0, 1));
      step();
      if (acc) n_acc++;
    end
    chk("rand_beats", n_acc, 1000);
    drain();
`ifdef RC_CPL_ADAPT_STATS_EN
    chk("rand_cpl", stats_cpl, 16'(n_cpl));
    chk("rand_pois", stats_poison, 16'(n_pois));
    chk("rand_disc", stats_disc, 16'(n_disc));

    force dut.stats_cpl_q = 16'hFFFF;
    idle(1);
    release dut.stats_cpl_q;
    send(desc(7'h0, 12'd4, 1'b0, 10'd1, 16'h1, 8'h2, 16'h3, 3'd0, 2'd0,
              1'b0), 16'h000F, 1'b1, 1'b0);
    idle(1);
    chk("stats_sat", stats_cpl, 16'hFFFF);
    stats_clr = 1'b1;
    send(desc(7'h0, 12'd4, 1'b0, 10'd1, 16'h1, 8'h2, 16'h3, 3'd0, 2'd0,
              1'b1), 16'h000F, 1'b1, 1'b1);
    stats_clr = 1'b0;
    idle(1);
    chk("stats_clr_wins", {stats_cpl, stats_poison, stats_disc}, 0);
`else
    chk("stats_off_end", {stats_cpl, stats_poison, stats_disc}, 0);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
